// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bundles the three sides of the data-RAM arbiter.
//   core side : c_rd, c_wr, c_addr, c_wdata -> c_rdata, c_rvalid, c_stall
//   DMA side  : d_req, d_we, d_addr, d_wdata -> d_gnt, d_rdata, d_rvalid
//   RAM side  : ram_wren, ram_wread, ram_address, ram_data <- ram_q
// Modports:
//   slave  - the arbiter itself
//   master - the surrounding environment (core, DMA/loader and RAM)
interface ram_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              c_rd;
    logic              c_wr;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic [DATA_W-1:0] c_rdata;
    logic              c_rvalid;
    logic              c_stall;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic [DATA_W-1:0] d_rdata;
    logic              d_rvalid;

    logic              ram_wren;
    logic              ram_wread;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data;
    logic [DATA_W-1:0] ram_q;

    modport slave (
        input  c_rd, c_wr, c_addr, c_wdata,
        output c_rdata, c_rvalid, c_stall,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rdata, d_rvalid,
        output ram_wren, ram_wread, ram_address, ram_data,
        input  ram_q
    );

    modport master (
        output c_rd, c_wr, c_addr, c_wdata,
        input  c_rdata, c_rvalid, c_stall,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rdata, d_rvalid,
        input  ram_wren, ram_wread, ram_address, ram_data,
        output ram_q
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single-port data RAM between the core load/store
// port and a DMA/loader port. One RAM access per cycle, winner picked
// combinationally and driven to the RAM in the same cycle. Read data comes
// back one cycle later; only the rvalid flags say whose data it is.
//
// Ports:
//   CLK      - clock, all state on the rising edge
//   RESET_N  - asynchronous active-low reset
//   bus      - ram_arbiter_if.slave (core, DMA and RAM sides)
//
// Parameters: ADDR_W (word address width), DATA_W, STARVE_LIMIT (1..255).
//
// Optional feature: define ARB_STARVE_GUARD_EN to add the DMA starvation
// guard. Without it the core has strict priority and the DMA can starve.
module ram_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input logic          CLK,
    input logic          RESET_N,
    ram_arbiter_if.slave bus
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
        $error("ram_arbiter: STARVE_LIMIT must be within 1..255");
    end

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } ram_cmd_t;

    logic     core_req;
    logic     force_dma;
    logic     dma_win;
    logic     core_win;
    logic     any_win;
    logic     dma_gnt_raw;
    ram_cmd_t core_cmd;
    ram_cmd_t dma_cmd;
    ram_cmd_t win_cmd;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    owner_t            rd_owner;

    assign core_req = bus.c_rd | bus.c_wr;

`ifdef ARB_STARVE_GUARD_EN
    // Counts cycles the DMA has been left waiting; reaching the limit makes
    // the DMA win over the core for one cycle.
    logic [7:0] starve_cnt;

    assign force_dma = bus.d_req && (starve_cnt == 8'(STARVE_LIMIT));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            starve_cnt <= '0;
        else if (!bus.d_req || dma_gnt_raw)
            starve_cnt <= '0;
        else
            starve_cnt <= starve_cnt + 8'd1;
    end
`else
    assign force_dma = 1'b0;
`endif

    assign dma_win     = bus.d_req & (~core_req | force_dma);
    assign core_win    = core_req & ~dma_win;
    assign any_win     = dma_win | core_win;
    assign dma_gnt_raw = bus.d_req & dma_win;

    assign core_cmd = '{we: bus.c_wr, addr: bus.c_addr, wdata: bus.c_wdata};
    assign dma_cmd  = '{we: bus.d_we, addr: bus.d_addr, wdata: bus.d_wdata};
    assign win_cmd  = dma_win ? dma_cmd : core_cmd;

    // Handshake and RAM strobes are held low for as long as reset is applied,
    // not only after the first clock edge.
    assign bus.c_stall   = RESET_N & core_req & ~core_win;
    assign bus.d_gnt     = RESET_N & dma_gnt_raw;
    assign bus.ram_wren  = RESET_N & any_win &  win_cmd.we;
    assign bus.ram_wread = RESET_N & any_win & ~win_cmd.we;

    // Address/data keep the last granted command on idle cycles.
    assign bus.ram_address = any_win ? win_cmd.addr  : addr_q;
    assign bus.ram_data    = any_win ? win_cmd.wdata : data_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_owner <= OWN_NONE;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            if (any_win && !win_cmd.we)
                rd_owner <= dma_win ? OWN_DMA : OWN_CORE;
            else
                rd_owner <= OWN_NONE;
            if (any_win) begin
                addr_q <= win_cmd.addr;
                data_q <= win_cmd.wdata;
            end
        end
    end

    // RAM output goes to both ports; the owner register qualifies it.
    assign bus.c_rdata  = bus.ram_q;
    assign bus.d_rdata  = bus.ram_q;
    assign bus.c_rvalid = (rd_owner == OWN_CORE);
    assign bus.d_rvalid = (rd_owner == OWN_DMA);

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tb_init = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(8)) dut (
        .CLK    (clk),
        .RESET_N(rst_n),
        .bus    (bus)
    );

    // Background contents of never-written words.
    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        if (a == 10'h010) return 32'hDEAD_BEEF;
        return {16'hC0DE, 6'h0, a};
    endfunction

    // RAM model: registered read, write at the clock edge.
    logic [DW-1:0] wmem [DEPTH];
    logic          wvld [DEPTH];
    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < DEPTH; i++) wvld[i] <= 1'b0;
        end else if (bus.ram_wren) begin
            wmem[bus.ram_address] <= bus.ram_data;
            wvld[bus.ram_address] <= 1'b1;
        end
        if (bus.ram_wread)
            bus.ram_q <= wvld[bus.ram_address] ? wmem[bus.ram_address] : init_val(bus.ram_address);
    end

    // Reference memory: only what the bench itself chose to write.
    logic [DW-1:0] ref_wr [int];
    function automatic logic [DW-1:0] exp_val(input logic [AW-1:0] a);
        return ref_wr.exists(int'(a)) ? ref_wr[int'(a)] : init_val(a);
    endfunction

    typedef struct {
        logic          is_dma;
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t sbq[$];

    // Scoreboard: read returns must arrive in the predicted cycle, in order.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && !tb_init) begin
            if (bus.c_rvalid && bus.d_rvalid) begin
                total++; bad++;
                $display("FAIL rvalid_overlap cyc=%0d: both rvalid high, want at most one", cyc);
            end
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                total++;
                if (e.is_dma) begin
                    if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== e.data) begin
                        bad++;
                        $display("FAIL d_read cyc=%0d: got rvalid=%b data=%h want rvalid=1 data=%h",
                                 cyc, bus.d_rvalid, bus.d_rdata, e.data);
                    end
                end else begin
                    if (bus.c_rvalid !== 1'b1 || bus.c_rdata !== e.data) begin
                        bad++;
                        $display("FAIL c_read cyc=%0d: got rvalid=%b data=%h want rvalid=1 data=%h",
                                 cyc, bus.c_rvalid, bus.c_rdata, e.data);
                    end
                end
            end else if (bus.c_rvalid || bus.d_rvalid) begin
                total++; bad++;
                $display("FAIL stray_rvalid cyc=%0d: got c=%b d=%b want 0 0", cyc, bus.c_rvalid, bus.d_rvalid);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic crd, input logic cwr, input logic [AW-1:0] ca, input logic [DW-1:0] cw,
                         input logic dr, input logic dwe, input logic [AW-1:0] da, input logic [DW-1:0] dw);
        bus.c_rd = crd; bus.c_wr = cwr; bus.c_addr = ca; bus.c_wdata = cw;
        bus.d_req = dr; bus.d_we = dwe; bus.d_addr = da; bus.d_wdata = dw;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic idle_cycle();
        next_cycle();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1, 0, 10'h001, '0, 1, 0, 10'h002, '0);
        @(negedge clk);
        total++;
        if ({bus.ram_wren, bus.ram_wread, bus.d_gnt, bus.c_stall, bus.c_rvalid, bus.d_rvalid} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {bus.ram_wren, bus.ram_wread, bus.d_gnt, bus.c_stall, bus.c_rvalid, bus.d_rvalid});
        end
        repeat (2) @(posedge clk);
        #1 tb_init = 1'b0;
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycle();
    endtask

    task automatic test_core_read();
        next_cycle();
        drive(1, 0, 10'h010, '0, 0, 0, '0, '0);
        sbq.push_back('{1'b0, exp_val(10'h010), cyc + 1});
        @(negedge clk);
        total++;
        if ({bus.ram_wread, bus.ram_wren, bus.c_stall} !== 3'b100 || bus.ram_address !== 10'h010) begin
            bad++;
            $display("FAIL core_read_issue: got wread/wren/stall=%b addr=%h want 100 addr=010",
                     {bus.ram_wread, bus.ram_wren, bus.c_stall}, bus.ram_address);
        end
        idle_cycle();
    endtask

    task automatic test_dma_write();
        next_cycle();
        drive(0, 0, '0, '0, 1, 1, 10'h3FF, 32'h1234_5678);
        ref_wr[10'h3FF] = 32'h1234_5678;
        @(negedge clk);
        total++;
        if ({bus.d_gnt, bus.c_stall, bus.ram_wren, bus.ram_wread} !== 4'b1010 ||
            bus.ram_address !== 10'h3FF || bus.ram_data !== 32'h1234_5678) begin
            bad++;
            $display("FAIL dma_write_issue: got gnt/stall/wren/wread=%b addr=%h data=%h want 1010 3ff 12345678",
                     {bus.d_gnt, bus.c_stall, bus.ram_wren, bus.ram_wread}, bus.ram_address, bus.ram_data);
        end
        idle_cycle();
        total++;
        if ({bus.ram_wren, bus.ram_wread} !== 2'b00 || bus.ram_address !== 10'h3FF || bus.ram_data !== 32'h1234_5678) begin
            bad++;
            $display("FAIL idle_hold: got wren/wread=%b addr=%h data=%h want 00 3ff 12345678",
                     {bus.ram_wren, bus.ram_wread}, bus.ram_address, bus.ram_data);
        end
        next_cycle();
        drive(1, 0, 10'h3FF, '0, 0, 0, '0, '0);
        sbq.push_back('{1'b0, exp_val(10'h3FF), cyc + 1});
        @(negedge clk);
        idle_cycle();
    endtask

    task automatic test_contention();
        next_cycle();
        drive(0, 1, 10'h020, 32'hCAFE_F00D, 1, 0, 10'h030, '0);
        ref_wr[10'h020] = 32'hCAFE_F00D;
        @(negedge clk);
        total++;
        if ({bus.c_stall, bus.d_gnt, bus.ram_wren} !== 3'b001 || bus.ram_address !== 10'h020) begin
            bad++;
            $display("FAIL contention_core_wins: got stall/gnt/wren=%b addr=%h want 001 020",
                     {bus.c_stall, bus.d_gnt, bus.ram_wren}, bus.ram_address);
        end
        next_cycle();
        drive(0, 0, '0, '0, 1, 0, 10'h030, '0);
        sbq.push_back('{1'b1, exp_val(10'h030), cyc + 1});
        @(negedge clk);
        total++;
        if ({bus.d_gnt, bus.ram_wread} !== 2'b11 || bus.ram_address !== 10'h030) begin
            bad++;
            $display("FAIL contention_dma_retry: got gnt/wread=%b addr=%h want 11 030",
                     {bus.d_gnt, bus.ram_wread}, bus.ram_address);
        end
        next_cycle();
        drive(1, 0, 10'h020, '0, 0, 0, '0, '0);
        sbq.push_back('{1'b0, exp_val(10'h020), cyc + 1});
        @(negedge clk);
        idle_cycle();
    endtask

    task automatic test_starvation();
        logic dma_pending = 1'b1;
        int   served = 0;
        logic exp_gnt;
        for (int i = 1; i <= 20; i++) begin
            next_cycle();
`ifdef ARB_STARVE_GUARD_EN
            exp_gnt = (i == 9);
`else
            exp_gnt = 1'b0;
`endif
            drive(1, 0, 10'(10'h100 + served), '0, dma_pending, 0, 10'h040, '0);
            if (exp_gnt) begin
                sbq.push_back('{1'b1, exp_val(10'h040), cyc + 1});
            end else begin
                sbq.push_back('{1'b0, exp_val(10'(10'h100 + served)), cyc + 1});
                served++;
            end
            @(negedge clk);
            total++;
            if ({bus.d_gnt, bus.c_stall} !== {exp_gnt, exp_gnt}) begin
                bad++;
                $display("FAIL starve_cycle%0d: got gnt/stall=%b%b want %b%b",
                         i, bus.d_gnt, bus.c_stall, exp_gnt, exp_gnt);
            end
            if (exp_gnt) dma_pending = 1'b0;
        end
        if (dma_pending) begin
            next_cycle();
            drive(0, 0, '0, '0, 1, 0, 10'h040, '0);
            sbq.push_back('{1'b1, exp_val(10'h040), cyc + 1});
            @(negedge clk);
            total++;
            if (bus.d_gnt !== 1'b1) begin
                bad++;
                $display("FAIL starve_release: got gnt=%b want 1", bus.d_gnt);
            end
        end
        idle_cycle();
    endtask

    task automatic test_reset_drop();
        next_cycle();
        drive(0, 0, '0, '0, 1, 0, 10'h050, '0);
        @(negedge clk);
        total++;
        if (bus.d_gnt !== 1'b1) begin
            bad++;
            $display("FAIL drop_grant: got gnt=%b want 1", bus.d_gnt);
        end
        #2 rst_n = 1'b0;
        bus.c_rd = 1'b1;
        #1;
        total++;
        if ({bus.ram_wren, bus.ram_wread, bus.d_gnt, bus.c_stall, bus.c_rvalid, bus.d_rvalid} !== 6'b0) begin
            bad++;
            $display("FAIL reset_forced_low: got %b want 000000",
                     {bus.ram_wren, bus.ram_wread, bus.d_gnt, bus.c_stall, bus.c_rvalid, bus.d_rvalid});
        end
        next_cycle();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        @(negedge clk);
        total++;
        if ({bus.c_rvalid, bus.d_rvalid} !== 2'b00) begin
            bad++;
            $display("FAIL drop_in_reset: got c/d rvalid=%b%b want 00", bus.c_rvalid, bus.d_rvalid);
        end
        #2 rst_n = 1'b1;
        idle_cycle();
        total++;
        if ({bus.c_rvalid, bus.d_rvalid} !== 2'b00) begin
            bad++;
            $display("FAIL drop_after_release: got c/d rvalid=%b%b want 00", bus.c_rvalid, bus.d_rvalid);
        end
        next_cycle();
        drive(1, 0, 10'h050, '0, 0, 0, '0, '0);
        sbq.push_back('{1'b0, exp_val(10'h050), cyc + 1});
        @(negedge clk);
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        logic is_dma;
        logic [AW-1:0] a;
        for (int i = 0; i < 16; i++) begin
            next_cycle();
            is_dma = (i % 2 == 0);
            a = 10'(10'h200 + i);
            if (is_dma) drive(0, 0, '0, '0, 1, 0, a, '0);
            else        drive(1, 0, a, '0, 0, 0, '0, '0);
            sbq.push_back('{is_dma, exp_val(a), cyc + 1});
            @(negedge clk);
            total++;
            if (bus.ram_wread !== 1'b1 || bus.ram_address !== a || bus.c_stall !== 1'b0 || bus.d_gnt !== is_dma) begin
                bad++;
                $display("FAIL b2b_issue%0d: got wread=%b addr=%h stall=%b gnt=%b want 1 %h 0 %b",
                         i, bus.ram_wread, bus.ram_address, bus.c_stall, bus.d_gnt, a, is_dma);
            end
        end
        idle_cycle();
        idle_cycle();
    endtask

    initial begin
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        test_reset();
        test_core_read();
        test_dma_write();
        test_contention();
        test_starvation();
        test_reset_drop();
        test_back_to_back();
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL pending_reads: got %0d outstanding want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Arbitrates the single-port data RAM between the core's load/store port and a DMA/loader port, so a host can preload or inspect data memory while the core runs. It sits between `core` and `RAM` in the top level. It drives `wren`/`wread`/`address`/`data`, stalls the core when the DMA owns the RAM, and returns read data with a fixed one-cycle latency. Default policy is fixed core priority, with an optional starvation guard for the DMA port.

## Interface
- `ADDR_W`, default 10: word address width; matches `daddr[11:2]`.
- `DATA_W`, default 32: data width.
- `STARVE_LIMIT`, default 8: consecutive cycles the DMA may wait before it is forced to win (guard builds only); legal range 1–255.

Ports:
- `CLK`  in  1  clock; all state on the rising edge.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `c_rd`  in  1  core read request (core `MemRead`).
- `c_wr`  in  1  core write request (core `MemWrite`); `c_rd & c_wr` is illegal.
- `c_addr`  in  ADDR_W  core word address.
- `c_wdata`  in  DATA_W  core write data.
- `c_rdata`  out  DATA_W  core read data.
- `c_rvalid`  out  1  `c_rdata` valid.
- `c_stall`  out  1  core request not served this cycle; core holds PC and request.
- `d_req`  in  1  DMA request; held with all fields until `d_gnt`.
- `d_we`  in  1  DMA write (1) or read (0).
- `d_addr`  in  ADDR_W  DMA word address.
- `d_wdata`  in  DATA_W  DMA write data.
- `d_gnt`  out  1  DMA request accepted this cycle.
- `d_rdata`  out  DATA_W  DMA read data.
- `d_rvalid`  out  1  `d_rdata` valid.
- `ram_wren`  out  1  to RAM `wren`.
- `ram_wread`  out  1  to RAM `wread`.
- `ram_address`  out  ADDR_W  to RAM `address`.
- `ram_data`  out  DATA_W  to RAM `data`.
- `ram_q`  in  DATA_W  from RAM `salida`; valid the cycle after a read is issued.

## Operation
- At most one RAM access per cycle. The winner is chosen combinationally from the current requests and state, and its command is driven to the RAM in the same cycle.
- Default policy: the core wins whenever `c_rd|c_wr`; otherwise the DMA wins if `d_req`.
- `c_stall = (c_rd|c_wr) & ~core_win`. `d_gnt = d_req & dma_win`.
- Idle (no winner): `ram_wren=ram_wread=0`; address and data hold their last values.
- Read return register `rd_owner`: 2 bits {NONE, CORE, DMA}, set to the winner of each read, NONE otherwise.
  - Next cycle: `c_rvalid = (rd_owner==CORE)`, `d_rvalid = (rd_owner==DMA)`.
  - Both `c_rdata` and `d_rdata` are wired to `ram_q`; only the rvalid flags are qualified.
- Write: RAM is updated at the edge that ends the grant cycle. No rvalid is produced.
- Back-to-back accesses from either port are allowed every cycle; read data returns in order.

## Timing
- Reset (RESET_N low, asynchronous): `rd_owner=NONE`, starvation counter 0, `c_rvalid=d_rvalid=0`. While reset is asserted, `ram_wren`, `ram_wread`, `d_gnt` and `c_stall` are forced to 0.
- Read latency: request in cycle N, data plus rvalid in cycle N+1, for both ports. Write latency: 0; write completes at the end of cycle N.
- Stall: zero extra cycles when the core is uncontested. Under the guard, each forced DMA win adds exactly one stall cycle.
- Simultaneous core and DMA requests: exactly one is served. The loser sees `c_stall=1` or `d_gnt=0` and retries the next cycle.
- DMA read issued in cycle N followed by a core read in N+1: `d_rvalid` in N+1, `c_rvalid` in N+2; no overlap.
- Reset asserted with a read outstanding: the read is dropped and no rvalid appears after release.
- `d_req` deasserted before `d_gnt`: this is a protocol violation; the arbiter simply stops considering the request.

## Configuration
- `ARB_STARVE_GUARD_EN` defined:
  - An 8-bit counter increments each cycle `d_req & ~d_gnt`, and clears on `d_gnt` or when `d_req` is low.
  - When the counter equals `STARVE_LIMIT`, the DMA wins the next cycle regardless of core requests, and the counter clears.
- `ARB_STARVE_GUARD_EN` undefined: strict core priority, with no counter logic synthesized. A continuously busy core can starve the DMA indefinitely.

## Test plan
- Core read only, addr 0x010, RAM holds 0xDEADBEEF -> `ram_wread=1` in N, `c_rvalid=1` and `c_rdata=0xDEADBEEF` in N+1, `c_stall=0`.
- DMA write addr 0x3FF data 0x12345678 with core idle -> `d_gnt=1` same cycle; a following core read of 0x3FF returns 0x12345678.
- Core write and DMA read in the same cycle (default build) -> core served, `c_stall=0`, `d_gnt=0`. With the core idle next cycle, `d_gnt=1` and `d_rvalid` the cycle after.
- Guard on, STARVE_LIMIT=8, core requests every cycle, `d_req` held -> `d_gnt=1` on the 9th cycle with `c_stall=1` that cycle only. Guard off -> `d_gnt` never asserts.
- DMA read granted, RESET_N pulsed low in the next cycle before the edge -> `d_rvalid` stays 0, all outputs 0 during reset, and normal operation resumes after release.
- Alternating DMA read / core read every cycle for 16 cycles -> rvalid flags alternate with correct data per address and no cycle with both asserted.
